// File: rtl/ej32_pkg.sv
// rtl/ej32_pkg.sv - shared eJ32 boot loader types and constants
package ej32_pkg;

    typedef enum logic [1:0] {
        HDR_HI = 2'd0,
        HDR_LO = 2'd1,
        COPY   = 2'd2,
        DONE   = 2'd3
    } boot_state_e;

    localparam int          HDR_BYTES    = 2;
    localparam logic [31:0] DEF_DST_BASE = 32'h0000_0000;
    localparam logic [15:0] DEF_MAX_LEN  = 16'h1000;

endpackage

// File: rtl/ej32_boot_loader.sv
// rtl/ej32_boot_loader.sv - copies a length-prefixed boot ROM image into RAM
// and holds the core until the copy and its additive checksum are complete.
module ej32_boot_loader
    import ej32_pkg::*;
#(
    parameter logic [31:0] DST_BASE = DEF_DST_BASE,
    parameter logic [15:0] MAX_LEN  = DEF_MAX_LEN
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        reload,
    output logic [31:0] rom_a,
    input  logic [7:0]  rom_d,
    output logic [31:0] ram_a,
    output logic [7:0]  ram_d,
    output logic        ram_we,
    output logic        cpu_hold,
    output logic        done,
    output logic        err,
    output logic [7:0]  csum
);

    boot_state_e state_q, state_d;
    logic [31:0] rom_a_q, rom_a_d;
    logic [31:0] ram_a_q, ram_a_d;
    logic [7:0]  ram_d_q, ram_d_d;
    logic        ram_we_q, ram_we_d;
    logic        err_q, err_d;
    logic [7:0]  csum_q, csum_d;
    logic [7:0]  len_hi_q, len_hi_d;
    logic [15:0] len_q, len_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] hdr_len;

    always_comb begin
        state_d  = state_q;
        rom_a_d  = rom_a_q;
        ram_a_d  = ram_a_q;
        ram_d_d  = ram_d_q;
        ram_we_d = 1'b0;
        err_d    = err_q;
        csum_d   = csum_q;
        len_hi_d = len_hi_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        hdr_len  = {len_hi_q, rom_d};

        case (state_q)
            HDR_HI: begin
                rom_a_d = rom_a_q + 32'd1;
                // ROM data is one cycle behind the address; byte 0 is valid once rom_a has reached 1.
                if (rom_a_q == 32'(HDR_BYTES - 1)) begin
                    len_hi_d = rom_d;
                    state_d  = HDR_LO;
                end
            end
            HDR_LO: begin
                rom_a_d = rom_a_q + 32'd1;
                cnt_d   = 16'd0;
                state_d = COPY;
                if (hdr_len > MAX_LEN) begin
                    len_d = MAX_LEN;
                    err_d = 1'b1;
                end else begin
                    len_d = hdr_len;
                end
            end
            COPY: begin
                rom_a_d = rom_a_q + 32'd1;
                if (cnt_q == len_q) begin
                    state_d = DONE;
                end else begin
                    ram_we_d = 1'b1;
                    ram_a_d  = DST_BASE + {16'd0, cnt_q};
                    ram_d_d  = rom_d;
                    csum_d   = csum_q + rom_d;
                    cnt_d    = cnt_q + 16'd1;
                end
            end
            DONE: begin
                if (reload) begin
                    state_d = HDR_HI;
                    rom_a_d = 32'd0;
                    ram_a_d = DST_BASE;
                    csum_d  = 8'd0;
                    err_d   = 1'b0;
                    cnt_d   = 16'd0;
                end
            end
            default: state_d = HDR_HI;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= HDR_HI;
            rom_a_q  <= 32'd0;
            ram_a_q  <= DST_BASE;
            ram_d_q  <= 8'd0;
            ram_we_q <= 1'b0;
            err_q    <= 1'b0;
            csum_q   <= 8'd0;
            len_hi_q <= 8'd0;
            len_q    <= 16'd0;
            cnt_q    <= 16'd0;
        end else begin
            state_q  <= state_d;
            rom_a_q  <= rom_a_d;
            ram_a_q  <= ram_a_d;
            ram_d_q  <= ram_d_d;
            ram_we_q <= ram_we_d;
            err_q    <= err_d;
            csum_q   <= csum_d;
            len_hi_q <= len_hi_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
        end
    end

    assign rom_a    = rom_a_q;
    assign ram_a    = ram_a_q;
    assign ram_d    = ram_d_q;
    assign ram_we   = ram_we_q;
    assign err      = err_q;
    assign csum     = csum_q;
    assign done     = (state_q == DONE);
    assign cpu_hold = (state_q != DONE);

endmodule

// File: tb/tb_ej32_boot_loader.sv
// tb/tb_ej32_boot_loader.sv - randomized self-checking bench for ej32_boot_loader
module tb_ej32_boot_loader;

    localparam int          MAXL = 'h1000;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        reload = 1'b0;
    logic [31:0] rom_a, ram_a;
    logic [7:0]  rom_d = 8'd0;
    logic [7:0]  ram_d, csum;
    logic        ram_we, cpu_hold, done, err;

    logic [7:0] rom_mem [0:8191];
    logic [7:0] ram_mem [0:65535];

    int total = 0;
    int bad = 0;
    int exp_n;
    bit exp_err;
    logic [7:0] exp_csum;

    ej32_boot_loader dut (
        .clk(clk), .rst_n(rst_n), .reload(reload),
        .rom_a(rom_a), .rom_d(rom_d),
        .ram_a(ram_a), .ram_d(ram_d), .ram_we(ram_we),
        .cpu_hold(cpu_hold), .done(done), .err(err), .csum(csum)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_d <= rom_mem[rom_a[12:0]];
    always @(posedge clk) if (ram_we) ram_mem[ram_a[15:0]] <= ram_d;

    task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_update();
        int hdr;
        int s;
        hdr = {rom_mem[0], rom_mem[1]};
        exp_err = (hdr > MAXL);
        exp_n = exp_err ? MAXL : hdr;
        s = 0;
        for (int i = 0; i < exp_n; i++) s += rom_mem[i + 2];
        exp_csum = 8'(s % 256);
    endtask

    task automatic build(input logic [15:0] hdr, input int fill);
        for (int i = 0; i < 8192; i++) rom_mem[i] = (fill < 0) ? 8'($urandom) : 8'(fill);
        rom_mem[0] = hdr[15:8];
        rom_mem[1] = hdr[7:0];
        for (int i = 0; i < 65536; i++) ram_mem[i] = 8'h5A;
        model_update();
    endtask

    task automatic check_reset(input string tag);
        expect_eq({tag, "_addr"}, {rom_a, ram_a}, {32'd0, BASE});
        expect_eq({tag, "_ctrl"}, {ram_d, ram_we, cpu_hold, done, err, csum},
                  {8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0});
    endtask

    task automatic do_reload();
        reload = 1'b1;
        @(posedge clk); #1;
        reload = 1'b0;
        expect_eq("reload_ack", {rom_a, done, cpu_hold}, {32'd0, 1'b0, 1'b1});
    endtask

    task automatic run_load(input int reload_at, input int abort_at);
        int errs;
        for (int k = 1; k <= exp_n + 4; k++) begin
            @(posedge clk); #1;
            expect_eq("rom_a", rom_a, 64'(k));
            if (k >= 4 && k <= exp_n + 3)
                expect_eq("wr", {ram_we, ram_a, ram_d}, {1'b1, BASE + 32'(k - 4), rom_mem[k - 2]});
            else
                expect_eq("we_idle", ram_we, 0);
            expect_eq("done_hold", {done, cpu_hold}, (k == exp_n + 4) ? 2'b10 : 2'b01);
            reload = (k == reload_at);
            if (k == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_reset("abort");
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
        end
        expect_eq("csum", csum, exp_csum);
        expect_eq("err", err, exp_err);
        for (int j = 0; j < 3; j++) begin
            @(posedge clk); #1;
            expect_eq("frozen", {rom_a, ram_we, done, cpu_hold}, {32'(exp_n + 4), 1'b0, 1'b1, 1'b0});
        end
        errs = 0;
        for (int i = 0; i < exp_n; i++) if (ram_mem[i] !== rom_mem[i + 2]) errs++;
        if (ram_mem[exp_n] !== 8'h5A) errs++;
        expect_eq("ram_img", errs, 0);
    endtask

    initial begin
        build(16'h0004, -1);
        rom_mem[2] = 8'h11; rom_mem[3] = 8'h22; rom_mem[4] = 8'h33; rom_mem[5] = 8'h44;
        model_update();
        repeat (2) @(posedge clk);
        #1;
        check_reset("por");
        @(negedge clk);
        rst_n = 1'b1;
        run_load(0, 0);
        expect_eq("t1_csum", csum, 8'hAA);

        build(16'h0000, -1);
        do_reload();
        run_load(0, 0);
        expect_eq("t2_csum", csum, 8'h00);

        build(16'hFFFF, -1);
        do_reload();
        run_load(0, 0);
        expect_eq("t3_err", err, 1'b1);

        build(16'd300, 'hFF);
        do_reload();
        run_load(0, 0);
        expect_eq("t4_csum", csum, 8'hD4);

        build(16'd20, -1);
        do_reload();
        run_load(0, 10);
        run_load(0, 0);

        build(16'd50, -1);
        do_reload();
        run_load(20, 0);
        do_reload();
        run_load(0, 0);

        for (int t = 0; t < 5; t++) begin
            build(16'((t == 4) ? $urandom_range(MAXL + 1, 'h1400) : $urandom_range(1, 700)), -1);
            do_reload();
            run_load(0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
